// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// Instruction fetch sequencer: one outstanding imem request, single-entry hand-off to the decoder.
// Optional FETCH_MISALIGN_CHECK_EN: a misaligned jump target raises a sticky fault and halts the unit.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    input  logic        jump_i,
    input  logic [31:0] jump_addr_i,
    output logic        fault_o
);
    // state | meaning
    // IDLE  | out of reset, loads the first fetch address
    // FETCH | request outstanding at pc
    // VALID | fetched instruction held for the decoder
    // HALT  | misaligned jump seen, dead until reset
    typedef enum logic [1:0] {IDLE, FETCH, VALID, HALT} state_t;

    localparam logic [31:0] NOP = 32'h00000013;

    state_t      state;
    logic [31:0] pc;
    logic        flush;
    logic [31:0] flush_addr;
    logic [31:0] jump_tgt;
    logic [31:0] redirect;
    logic        jump_bad;

    assign jump_tgt = {jump_addr_i[31:2], 2'b00};
    assign redirect = jump_i ? jump_tgt : flush_addr;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign jump_bad = jump_i && (jump_addr_i[1:0] != 2'b00) && (state != HALT);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fault_o <= 1'b0;
        end else if (jump_bad) begin
            fault_o <= 1'b1;
        end
    end
`else
    logic unused_jump_lsb;
    assign unused_jump_lsb = ^jump_addr_i[1:0];
    assign jump_bad        = 1'b0;
    assign fault_o         = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            flush         <= 1'b0;
            flush_addr    <= 32'h00000000;
            imem_req_o    <= 1'b0;
            imem_addr_o   <= RESET_PC;
            instr_o       <= NOP;
            instr_pc_o    <= 32'h00000000;
            instr_valid_o <= 1'b0;
        end else if (jump_bad) begin
            state         <= HALT;
            flush         <= 1'b0;
            imem_req_o    <= 1'b0;
            instr_valid_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state      <= FETCH;
                    imem_req_o <= 1'b1;
                    if (jump_i) begin
                        pc          <= jump_tgt;
                        imem_addr_o <= jump_tgt;
                    end else begin
                        imem_addr_o <= pc;
                    end
                end
                FETCH: begin
                    if (imem_ack_i) begin
                        flush <= 1'b0;
                        // A redirect seen during or before the ack kills the returned word.
                        if (jump_i || flush) begin
                            pc          <= redirect;
                            imem_addr_o <= redirect;
                        end else begin
                            instr_o       <= imem_data_i;
                            instr_pc_o    <= pc;
                            pc            <= pc + 32'd4;
                            state         <= VALID;
                            imem_req_o    <= 1'b0;
                            instr_valid_o <= 1'b1;
                        end
                    end else if (jump_i) begin
                        flush      <= 1'b1;
                        flush_addr <= jump_tgt;
                    end
                end
                VALID: begin
                    if (jump_i || instr_ready_i) begin
                        state         <= FETCH;
                        instr_valid_o <= 1'b0;
                        imem_req_o    <= 1'b1;
                        if (jump_i) begin
                            pc          <= jump_tgt;
                            imem_addr_o <= jump_tgt;
                        end else begin
                            imem_addr_o <= pc;
                        end
                    end
                end
                HALT: begin
                    imem_req_o    <= 1'b0;
                    instr_valid_o <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
// Scoreboard bench for fetch_unit: expected fetches are queued as stimulus is driven and
// matched against every instruction the unit presents to the decoder.
module tb_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] KEY    = 32'hDEAD_BEEF;
    localparam logic [31:0] BAD    = 32'hBAD0_BAD0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic        jump_i;
    logic [31:0] jump_addr_i;
    logic        fault_o;

    logic        mem_en;
    int          mem_lat;
    int          mem_wait = 0;
    logic        mem_ack  = 1'b0;
    logic [31:0] mem_data = 32'h0;
    logic        man_ack;
    logic [31:0] man_data;

    logic [31:0] obs_pc    [0:63];
    logic [31:0] obs_instr [0:63];
    int          obs_n      = 0;
    logic        prev_valid = 1'b0;
    int          rd         = 0;

    fetch_t      exp_q[$];
    int          tests_run = 0;
    int          fails     = 0;

    assign imem_ack_i  = mem_en ? mem_ack  : man_ack;
    assign imem_data_i = mem_en ? mem_data : man_data;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_data_i   (imem_data_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .jump_i        (jump_i),
        .jump_addr_i   (jump_addr_i),
        .fault_o       (fault_o)
    );

    always #5 clk_i = ~clk_i;

    // Memory: acks mem_lat cycles after it first sees req, word = address ^ KEY.
    always @(negedge clk_i) begin
        if (rst_i || !mem_en || imem_req_o !== 1'b1 || mem_ack) begin
            mem_ack  = 1'b0;
            mem_wait = 0;
        end else if (mem_wait >= mem_lat) begin
            mem_ack  = 1'b1;
            mem_data = imem_addr_o ^ KEY;
        end else begin
            mem_wait++;
        end
    end

    // Records every instruction presented to the decoder (valid rising edge).
    always @(negedge clk_i) begin
        if (rst_i) begin
            prev_valid = 1'b0;
        end else begin
            if (instr_valid_o === 1'b1 && !prev_valid && obs_n < 64) begin
                obs_pc[obs_n]    = instr_pc_o;
                obs_instr[obs_n] = instr_o;
                obs_n++;
            end
            prev_valid = (instr_valid_o === 1'b1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic pulse_ready();
        instr_ready_i = 1'b1;
        step();
        instr_ready_i = 1'b0;
    endtask

    task automatic expect_fetch(input logic [31:0] addr);
        fetch_t e;
        e.pc    = addr;
        e.instr = addr ^ KEY;
        exp_q.push_back(e);
    endtask

    task automatic wait_obs(input int budget, output bit ok, output logic [31:0] pc, output logic [31:0] ins);
        ok  = 1'b0;
        pc  = 32'hx;
        ins = 32'hx;
        for (int i = 0; i < budget; i++) begin
            if (obs_n > rd) begin
                ok  = 1'b1;
                pc  = obs_pc[rd];
                ins = obs_instr[rd];
                rd++;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        #1;
        tests_run++;
        if (imem_req_o !== 1'b0) begin fails++; $display("FAIL reset_req: got %b, required 0", imem_req_o); end
        tests_run++;
        if (imem_addr_o !== RST_PC) begin fails++; $display("FAIL reset_addr: got %h, required %h", imem_addr_o, RST_PC); end
        tests_run++;
        if (instr_o !== 32'h0000_0013) begin fails++; $display("FAIL reset_instr: got %h, required 00000013", instr_o); end
        tests_run++;
        if (instr_pc_o !== 32'h0) begin fails++; $display("FAIL reset_instr_pc: got %h, required 00000000", instr_pc_o); end
        tests_run++;
        if (instr_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b, required 0", instr_valid_o); end
        tests_run++;
        if (fault_o !== 1'b0) begin fails++; $display("FAIL reset_fault: got %b, required 0", fault_o); end
        mem_en  = 1'b1;
        mem_lat = 0;
        step();
        step();
        rst_i = 1'b0;
    endtask

    task automatic test_sequential();
        bit ok;
        logic [31:0] gp, gi;
        fetch_t e;
        for (int k = 0; k < 3; k++) expect_fetch(RST_PC + 32'(4 * k));
        for (int k = 0; k < 3; k++) begin
            wait_obs(20, ok, gp, gi);
            e = exp_q.pop_front();
            tests_run++;
            if (!ok || gp !== e.pc || gi !== e.instr) begin
                fails++;
                $display("FAIL seq_fetch%0d: got ok=%0d pc=%h instr=%h, required pc=%h instr=%h", k, ok, gp, gi, e.pc, e.instr);
            end
            if (k < 2) pulse_ready();
        end
    endtask

    task automatic test_stall();
        bit ok;
        logic [31:0] gp, gi;
        fetch_t e;
        for (int c = 0; c < 5; c++) begin
            step();
            tests_run++;
            if (instr_o !== (32'h108 ^ KEY) || instr_pc_o !== 32'h108 || imem_req_o !== 1'b0 || instr_valid_o !== 1'b1) begin
                fails++;
                $display("FAIL stall_hold%0d: got instr=%h pc=%h req=%b valid=%b, required %h 00000108 0 1",
                         c, instr_o, instr_pc_o, imem_req_o, instr_valid_o, 32'h108 ^ KEY);
            end
        end
        pulse_ready();
        tests_run++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h10C) begin
            fails++;
            $display("FAIL stall_next_req: got req=%b addr=%h, required 1 0000010c", imem_req_o, imem_addr_o);
        end
        expect_fetch(32'h10C);
        wait_obs(20, ok, gp, gi);
        e = exp_q.pop_front();
        tests_run++;
        if (!ok || gp !== e.pc || gi !== e.instr) begin
            fails++;
            $display("FAIL stall_fetch: got ok=%0d pc=%h instr=%h, required pc=%h instr=%h", ok, gp, gi, e.pc, e.instr);
        end
    endtask

    task automatic test_jump_fetch();
        bit ok;
        logic [31:0] gp, gi;
        fetch_t e;
        mem_en = 1'b0;
        pulse_ready();
        jump_i      = 1'b1;
        jump_addr_i = 32'h200;
        step();
        jump_i = 1'b0;
        tests_run++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h110) begin
            fails++;
            $display("FAIL jf_addr_hold1: got req=%b addr=%h, required 1 00000110", imem_req_o, imem_addr_o);
        end
        step();
        tests_run++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h110) begin
            fails++;
            $display("FAIL jf_addr_hold2: got req=%b addr=%h, required 1 00000110", imem_req_o, imem_addr_o);
        end
        man_ack  = 1'b1;
        man_data = BAD;
        step();
        man_ack = 1'b0;
        tests_run++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200 || instr_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL jf_redirect: got req=%b addr=%h valid=%b, required 1 00000200 0", imem_req_o, imem_addr_o, instr_valid_o);
        end
        mem_en = 1'b1;
        expect_fetch(32'h200);
        wait_obs(20, ok, gp, gi);
        e = exp_q.pop_front();
        tests_run++;
        if (!ok || gp !== e.pc || gi !== e.instr) begin
            fails++;
            $display("FAIL jf_fetch: got ok=%0d pc=%h instr=%h, required pc=%h instr=%h", ok, gp, gi, e.pc, e.instr);
        end
    endtask

    task automatic test_last_jump_wins();
        bit ok;
        logic [31:0] gp, gi;
        fetch_t e;
        mem_en = 1'b0;
        pulse_ready();
        jump_i      = 1'b1;
        jump_addr_i = 32'h600;
        step();
        jump_addr_i = 32'h700;
        step();
        jump_i = 1'b0;
        tests_run++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h204) begin
            fails++;
            $display("FAIL lw_addr_hold: got req=%b addr=%h, required 1 00000204", imem_req_o, imem_addr_o);
        end
        man_ack  = 1'b1;
        man_data = BAD;
        step();
        man_ack = 1'b0;
        tests_run++;
        if (imem_addr_o !== 32'h700 || instr_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL lw_redirect: got addr=%h valid=%b, required 00000700 0", imem_addr_o, instr_valid_o);
        end
        mem_en = 1'b1;
        expect_fetch(32'h700);
        wait_obs(20, ok, gp, gi);
        e = exp_q.pop_front();
        tests_run++;
        if (!ok || gp !== e.pc || gi !== e.instr) begin
            fails++;
            $display("FAIL lw_fetch: got ok=%0d pc=%h instr=%h, required pc=%h instr=%h", ok, gp, gi, e.pc, e.instr);
        end
    endtask

    task automatic test_jump_valid();
        bit ok;
        logic [31:0] gp, gi;
        fetch_t e;
        instr_ready_i = 1'b0;
        jump_i        = 1'b1;
        jump_addr_i   = 32'h300;
        step();
        jump_i = 1'b0;
        tests_run++;
        if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h300) begin
            fails++;
            $display("FAIL jv_redirect: got valid=%b req=%b addr=%h, required 0 1 00000300", instr_valid_o, imem_req_o, imem_addr_o);
        end
        expect_fetch(32'h300);
        wait_obs(20, ok, gp, gi);
        e = exp_q.pop_front();
        tests_run++;
        if (!ok || gp !== e.pc || gi !== e.instr) begin
            fails++;
            $display("FAIL jv_fetch: got ok=%0d pc=%h instr=%h, required pc=%h instr=%h", ok, gp, gi, e.pc, e.instr);
        end
    endtask

    task automatic test_jump_ack();
        bit ok;
        logic [31:0] gp, gi;
        fetch_t e;
        mem_en = 1'b0;
        pulse_ready();
        jump_i      = 1'b1;
        jump_addr_i = 32'h400;
        man_ack     = 1'b1;
        man_data    = BAD;
        step();
        jump_i  = 1'b0;
        man_ack = 1'b0;
        tests_run++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h400 || instr_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL ja_redirect: got req=%b addr=%h valid=%b, required 1 00000400 0", imem_req_o, imem_addr_o, instr_valid_o);
        end
        step();
        tests_run++;
        if (instr_valid_o !== 1'b0) begin fails++; $display("FAIL ja_discard: got valid=%b, required 0", instr_valid_o); end
        mem_en = 1'b1;
        expect_fetch(32'h400);
        wait_obs(20, ok, gp, gi);
        e = exp_q.pop_front();
        tests_run++;
        if (!ok || gp !== e.pc || gi !== e.instr) begin
            fails++;
            $display("FAIL ja_fetch: got ok=%0d pc=%h instr=%h, required pc=%h instr=%h", ok, gp, gi, e.pc, e.instr);
        end
    endtask

    task automatic test_reset_abandon();
        bit ok;
        logic [31:0] gp, gi;
        fetch_t e;
        mem_en = 1'b0;
        pulse_ready();
        tests_run++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h404) begin
            fails++;
            $display("FAIL ra_outstanding: got req=%b addr=%h, required 1 00000404", imem_req_o, imem_addr_o);
        end
        rst_i = 1'b1;
        #1;
        tests_run++;
        if (imem_req_o !== 1'b0 || imem_addr_o !== RST_PC) begin
            fails++;
            $display("FAIL ra_async: got req=%b addr=%h, required 0 %h", imem_req_o, imem_addr_o, RST_PC);
        end
        tests_run++;
        if (instr_valid_o !== 1'b0 || instr_o !== 32'h13) begin
            fails++;
            $display("FAIL ra_async_instr: got valid=%b instr=%h, required 0 00000013", instr_valid_o, instr_o);
        end
        step();
        rst_i       = 1'b0;
        man_ack     = 1'b1;
        man_data    = BAD;
        jump_i      = 1'b1;
        jump_addr_i = 32'h500;
        step();
        man_ack = 1'b0;
        jump_i  = 1'b0;
        tests_run++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h500 || instr_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL ra_idle_jump: got req=%b addr=%h valid=%b, required 1 00000500 0", imem_req_o, imem_addr_o, instr_valid_o);
        end
        step();
        tests_run++;
        if (instr_valid_o !== 1'b0) begin fails++; $display("FAIL ra_ack_ignored: got valid=%b, required 0", instr_valid_o); end
        mem_en = 1'b1;
        expect_fetch(32'h500);
        wait_obs(20, ok, gp, gi);
        e = exp_q.pop_front();
        tests_run++;
        if (!ok || gp !== e.pc || gi !== e.instr) begin
            fails++;
            $display("FAIL ra_fetch: got ok=%0d pc=%h instr=%h, required pc=%h instr=%h", ok, gp, gi, e.pc, e.instr);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [31:0] gp, gi;
        fetch_t e;
        jump_i      = 1'b1;
        jump_addr_i = 32'hFFFF_FFFC;
        step();
        jump_i = 1'b0;
        expect_fetch(32'hFFFF_FFFC);
        wait_obs(20, ok, gp, gi);
        e = exp_q.pop_front();
        tests_run++;
        if (!ok || gp !== e.pc || gi !== e.instr) begin
            fails++;
            $display("FAIL wrap_top: got ok=%0d pc=%h instr=%h, required pc=%h instr=%h", ok, gp, gi, e.pc, e.instr);
        end
        pulse_ready();
        tests_run++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
            fails++;
            $display("FAIL wrap_next_req: got req=%b addr=%h, required 1 00000000", imem_req_o, imem_addr_o);
        end
        expect_fetch(32'h0);
        wait_obs(20, ok, gp, gi);
        e = exp_q.pop_front();
        tests_run++;
        if (!ok || gp !== e.pc || gi !== e.instr) begin
            fails++;
            $display("FAIL wrap_zero: got ok=%0d pc=%h instr=%h, required pc=%h instr=%h", ok, gp, gi, e.pc, e.instr);
        end
    endtask

    task automatic test_misalign();
        bit ok;
        logic [31:0] gp, gi;
        fetch_t e;
        jump_i      = 1'b1;
        jump_addr_i = 32'h202;
        step();
        jump_i = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        tests_run++;
        if (fault_o !== 1'b1) begin fails++; $display("FAIL mis_fault: got %b, required 1", fault_o); end
        tests_run++;
        if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b0) begin
            fails++;
            $display("FAIL mis_halt: got valid=%b req=%b, required 0 0", instr_valid_o, imem_req_o);
        end
        for (int c = 0; c < 5; c++) begin
            step();
            tests_run++;
            if (imem_req_o !== 1'b0 || fault_o !== 1'b1) begin
                fails++;
                $display("FAIL mis_stay_halt%0d: got req=%b fault=%b, required 0 1", c, imem_req_o, fault_o);
            end
        end
`else
        tests_run++;
        if (fault_o !== 1'b0) begin fails++; $display("FAIL mis_no_fault: got %b, required 0", fault_o); end
        tests_run++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin
            fails++;
            $display("FAIL mis_aligned_req: got req=%b addr=%h, required 1 00000200", imem_req_o, imem_addr_o);
        end
        expect_fetch(32'h200);
        wait_obs(20, ok, gp, gi);
        e = exp_q.pop_front();
        tests_run++;
        if (!ok || gp !== e.pc || gi !== e.instr) begin
            fails++;
            $display("FAIL mis_fetch: got ok=%0d pc=%h instr=%h, required pc=%h instr=%h", ok, gp, gi, e.pc, e.instr);
        end
`endif
    endtask

    task automatic test_final();
        for (int c = 0; c < 4; c++) step();
        tests_run++;
        if (obs_n !== rd) begin
            fails++;
            $display("FAIL sb_extra: got %0d presented, required %0d", obs_n, rd);
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL sb_pending: got %0d unmatched, required 0", exp_q.size());
        end
    endtask

    initial begin
        rst_i         = 1'b0;
        instr_ready_i = 1'b0;
        jump_i        = 1'b0;
        jump_addr_i   = 32'h0;
        man_ack       = 1'b0;
        man_data      = 32'h0;
        mem_en        = 1'b0;
        mem_lat       = 0;
        step();
        step();
        test_reset();
        test_sequential();
        test_stall();
        test_jump_fetch();
        test_last_jump_wins();
        test_jump_valid();
        test_jump_ack();
        test_reset_abandon();
        test_wrap();
        test_misalign();
        test_final();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
